// File: rtl/mesh_term_tx.sv
// mesh_term_tx: formats local packets into the mesh layout and queues them in a FWFT FIFO
// that the router drains one word per pop pulse.
module mesh_term_tx #(
   parameter int ROWS       = 4,
   parameter int COLUMS     = 4,
   parameter int PCKG_SZ    = 32,
   parameter int FIFO_DEPTH = 16,
   localparam int PL_W      = PCKG_SZ - 17
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [3:0]         dst_row,
   input  logic [3:0]         dst_col,
   input  logic               mode,
   input  logic [PL_W-1:0]    payload,
   output logic               accept,
   input  logic               pop,
   output logic               pndng_i_in,
   output logic [PCKG_SZ-1:0] data_out_i_in,
   output logic               full,
   output logic               overflow,
   output logic               err_dest,
   output logic               underflow,
   output logic [15:0]        tx_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0] R_LAST = 4'(ROWS + 1);
   localparam logic [3:0] C_LAST = 4'(COLUMS + 1);
   localparam logic [3:0] R_MAX  = 4'(ROWS);
   localparam logic [3:0] C_MAX  = 4'(COLUMS);
   logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;
   logic               legal, pop_eff;
   // only terminal positions on the mesh border are reachable destinations
   always_comb begin
      legal = ((dst_row == 4'd0 || dst_row == R_LAST) && dst_col >= 4'd1 && dst_col <= C_MAX) ||
              ((dst_col == 4'd0 || dst_col == C_LAST) && dst_row >= 4'd1 && dst_row <= R_MAX);
      pndng_i_in    = count != '0;
      full          = count == (AW + 1)'(FIFO_DEPTH);
      pop_eff       = pop & pndng_i_in;
      accept        = push & legal & (~full | pop_eff);
      data_out_i_in = mem[rd_ptr];
   end
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= {8'h00, dst_row, dst_col, mode, payload};
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         tx_count  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         err_dest  <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
         count     <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop_eff};
         tx_count  <= tx_count + {15'd0, pop_eff};
         overflow  <= overflow | (push & legal & full & ~pop_eff);
         underflow <= underflow | (pop & ~pndng_i_in);
         err_dest  <= push & ~legal;
      end
   end
endmodule

// File: tb/tb_mesh_term_tx.sv
// tb_mesh_term_tx: randomized and directed checks of mesh_term_tx against a queue-based model.
module tb_mesh_term_tx;
   logic        clk = 0, reset = 1;
   logic        push = 0, pop = 0, mode = 0;
   logic [3:0]  dst_row = 0, dst_col = 0;
   logic [14:0] payload = 0;
   logic        accept, pndng_i_in, full, overflow, err_dest, underflow;
   logic [31:0] data_out_i_in;
   logic [15:0] tx_count;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] q[$];
   logic [15:0] m_tx;
   bit          m_ovf, m_unf, m_err, e_acc;

   mesh_term_tx dut (
      .clk(clk), .reset(reset), .push(push), .dst_row(dst_row), .dst_col(dst_col),
      .mode(mode), .payload(payload), .accept(accept), .pop(pop), .pndng_i_in(pndng_i_in),
      .data_out_i_in(data_out_i_in), .full(full), .overflow(overflow), .err_dest(err_dest),
      .underflow(underflow), .tx_count(tx_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bit legal(input logic [3:0] r, input logic [3:0] c);
      return ((r == 0 || r == 5) && c >= 1 && c <= 4) || ((c == 0 || c == 5) && r >= 1 && r <= 4);
   endfunction

   task automatic rand_legal(output logic [3:0] r, output logic [3:0] c);
      int k;
      k = $urandom_range(0, 15);
      if (k < 8) begin r = (k < 4) ? 4'd0 : 4'd5; c = 4'(k % 4 + 1); end
      else begin r = 4'(k % 4 + 1); c = (k < 12) ? 4'd0 : 4'd5; end
   endtask

   task automatic drive(input bit p, input logic [3:0] r, input logic [3:0] c, input bit m,
                        input logic [14:0] pl, input bit po);
      push = p; dst_row = r; dst_col = c; mode = m; payload = pl; pop = po;
      e_acc = p && legal(r, c) && (q.size() < 16 || (po && q.size() != 0));
      #1;
   endtask

   task automatic tick();
      bit pe, lg;
      pe = pop && q.size() != 0;
      lg = legal(dst_row, dst_col);
      if (pop && q.size() == 0) m_unf = 1;
      if (push && lg && !e_acc) m_ovf = 1;
      m_err = push && !lg;
      if (pe) begin void'(q.pop_front()); m_tx = m_tx + 16'd1; end
      if (e_acc) q.push_back({8'h00, dst_row, dst_col, mode, payload});
      @(posedge clk); #1;
      push = 0; pop = 0;
   endtask

   task automatic do_reset();
      push = 0; pop = 0; reset = 1;
      q.delete(); m_tx = 0; m_ovf = 0; m_unf = 0; m_err = 0;
      @(posedge clk); #1;
      reset = 0; #1;
   endtask

   task automatic push_legal();
      logic [3:0] r, c;
      rand_legal(r, c);
      drive(1, r, c, 1'($urandom_range(0, 1)), 15'($urandom_range(0, 32767)), 0);
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL reset_pndng got %b want 0", pndng_i_in); end
      n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
      n_chk++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got %b want 0", underflow); end
      n_chk++; if (err_dest !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_dest); end
      n_chk++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL reset_tx got %0d want 0", tx_count); end
   endtask

   task automatic test_basic();
      do_reset();
      drive(1, 4'd0, 4'd1, 1, 15'h1234, 0);
      n_chk++; if (accept !== 1'b1) begin n_fail++; $display("FAIL basic_accept got %b want 1", accept); end
      tick();
      n_chk++; if (pndng_i_in !== 1'b1) begin n_fail++; $display("FAIL basic_pndng got %b want 1", pndng_i_in); end
      n_chk++; if (data_out_i_in !== 32'h0001_9234) begin n_fail++; $display("FAIL basic_data got %h want 00019234", data_out_i_in); end
      drive(0, 4'd0, 4'd1, 0, 15'h0, 1);
      tick();
      n_chk++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL basic_pop_pndng got %b want 0", pndng_i_in); end
      n_chk++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL basic_tx got %0d want 1", tx_count); end
   endtask

   task automatic test_illegal();
      logic [3:0] rs [2] = '{4'd0, 4'd5};
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1, rs[i], rs[i], 0, 15'h7FFF, 0);
         n_chk++; if (accept !== 1'b0) begin n_fail++; $display("FAIL illegal_accept[%0d] got %b want 0", i, accept); end
         tick();
         n_chk++; if (err_dest !== 1'b1) begin n_fail++; $display("FAIL illegal_err[%0d] got %b want 1", i, err_dest); end
         n_chk++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL illegal_pndng[%0d] got %b want 0", i, pndng_i_in); end
         tick();
         n_chk++; if (err_dest !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clr[%0d] got %b want 0", i, err_dest); end
      end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         push_legal();
         n_chk++; if (accept !== (i < 16)) begin n_fail++; $display("FAIL fill_accept[%0d] got %b want %b", i, accept, i < 16); end
         tick();
         n_chk++; if (full !== (i >= 15)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full, i >= 15); end
      end
      n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %b want 1", overflow); end
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (data_out_i_in !== q[0]) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, data_out_i_in, q[0]); end
         drive(0, 4'd0, 4'd0, 0, 15'h0, 1);
         tick();
      end
      n_chk++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL drain_pndng got %b want 0", pndng_i_in); end
      n_chk++; if (tx_count !== 16'd16) begin n_fail++; $display("FAIL drain_tx got %0d want 16", tx_count); end
      n_chk++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_unf got %b want 0", underflow); end
   endtask

   task automatic test_full_push_pop();
      logic [3:0] r, c;
      do_reset();
      for (int i = 0; i < 16; i++) begin push_legal(); tick(); end
      for (int i = 0; i < 20; i++) begin
         rand_legal(r, c);
         drive(1, r, c, 1'($urandom_range(0, 1)), 15'($urandom_range(0, 32767)), 1);
         n_chk++; if (accept !== 1'b1) begin n_fail++; $display("FAIL pp_accept[%0d] got %b want 1", i, accept); end
         tick();
         n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL pp_full[%0d] got %b want 1", i, full); end
         n_chk++; if (data_out_i_in !== q[0]) begin n_fail++; $display("FAIL pp_data[%0d] got %h want %h", i, data_out_i_in, q[0]); end
      end
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (data_out_i_in !== q[0]) begin n_fail++; $display("FAIL pp_drain[%0d] got %h want %h", i, data_out_i_in, q[0]); end
         drive(0, 4'd0, 4'd0, 0, 15'h0, 1);
         tick();
      end
      n_chk++; if (tx_count !== 16'd36) begin n_fail++; $display("FAIL pp_tx got %0d want 36", tx_count); end
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_ovf got %b want 0", overflow); end
   endtask

   task automatic test_underflow();
      do_reset();
      drive(0, 4'd0, 4'd0, 0, 15'h0, 1);
      tick();
      n_chk++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b want 1", underflow); end
      n_chk++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL unf_tx got %0d want 0", tx_count); end
      drive(1, 4'd5, 4'd4, 0, 15'h0ABC, 1);
      n_chk++; if (accept !== 1'b1) begin n_fail++; $display("FAIL unf_push_accept got %b want 1", accept); end
      tick();
      n_chk++; if (pndng_i_in !== 1'b1) begin n_fail++; $display("FAIL unf_push_pndng got %b want 1", pndng_i_in); end
      n_chk++; if (data_out_i_in !== 32'h0054_0ABC) begin n_fail++; $display("FAIL unf_push_data got %h want 00540abc", data_out_i_in); end
      n_chk++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL unf_push_tx got %0d want 0", tx_count); end
   endtask

   task automatic test_random();
      logic [3:0] r, c;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            r = 4'($urandom_range(0, 6)); c = 4'($urandom_range(0, 6));
         end else rand_legal(r, c);
         drive(1'($urandom_range(0, 2) != 0), r, c, 1'($urandom_range(0, 1)),
               15'($urandom_range(0, 32767)), 1'($urandom_range(0, 2) == 0));
         n_chk++; if (accept !== e_acc) begin n_fail++; $display("FAIL rnd_accept[%0d] got %b want %b", i, accept, e_acc); end
         tick();
         n_chk++; if (pndng_i_in !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_pndng[%0d] got %b want %b", i, pndng_i_in, q.size() != 0); end
         if (q.size() != 0) begin
            n_chk++; if (data_out_i_in !== q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", i, data_out_i_in, q[0]); end
         end
         n_chk++; if (full !== (q.size() == 16)) begin n_fail++; $display("FAIL rnd_full[%0d] got %b want %b", i, full, q.size() == 16); end
         n_chk++; if ({overflow, underflow, err_dest} !== {m_ovf, m_unf, m_err}) begin
            n_fail++; $display("FAIL rnd_flags[%0d] got %b%b%b want %b%b%b", i, overflow, underflow, err_dest, m_ovf, m_unf, m_err); end
         n_chk++; if (tx_count !== m_tx) begin n_fail++; $display("FAIL rnd_tx[%0d] got %0d want %0d", i, tx_count, m_tx); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 6; i++) begin push_legal(); tick(); end
      drive(0, 4'd0, 4'd0, 0, 15'h0, 1);
      tick();
      drive(0, 4'd0, 4'd0, 0, 15'h0, 1);
      #2 reset = 1;
      #1;
      n_chk++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL mid_pndng got %b want 0", pndng_i_in); end
      n_chk++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL mid_tx got %0d want 0", tx_count); end
      @(posedge clk); #1;
      n_chk++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL mid_tx_hold got %0d want 0", tx_count); end
      pop = 0; reset = 0;
      q.delete(); m_tx = 0; m_ovf = 0; m_unf = 0; m_err = 0;
      tick();
      n_chk++; if ({pndng_i_in, underflow, overflow} !== 3'b000) begin
         n_fail++; $display("FAIL mid_after got %b%b%b want 000", pndng_i_in, underflow, overflow); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_illegal();
      test_fill_overflow();
      test_full_push_pop();
      test_underflow();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
